// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader: default memory size
// and the loader FSM state encoding.
package imem_pkg;

    localparam int unsigned MEM_BYTES = 4096;
    localparam int unsigned MEM_WORDS = MEM_BYTES / 4;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        WRITE,
        DONE,
        ERROR
    } state_e;

endpackage

// File: rtl/imem_word_packer.sv
// Packs a byte stream into 32-bit big-endian words: a 2-bit lane counter plus
// a shift register; word_ready flags the cycle the 4th byte is taken.
module imem_word_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_next,
    output logic        word_ready
);

    logic [1:0]  lane_q, lane_d;
    logic [31:0] shreg_q, shreg_d;

    always_comb begin
        lane_d  = lane_q;
        shreg_d = shreg_q;
        if (clear) begin
            lane_d  = '0;
            shreg_d = '0;
        end else if (byte_en) begin
            // Lane wraps 3 -> 0 as the word completes, so no partial word survives.
            lane_d  = lane_q + 2'd1;
            shreg_d = {shreg_q[23:0], byte_in};
        end
    end

    assign word_next  = shreg_d;
    assign word_ready = byte_en && !clear && (lane_q == 2'd3);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane_q  <= '0;
            shreg_q <= '0;
        end else begin
            lane_q  <= lane_d;
            shreg_q <= shreg_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into instruction memory one word at a
// time and holds the CPU in reset until a load completes successfully.
module imem_loader #(
    parameter int unsigned MEM_BYTES = imem_pkg::MEM_BYTES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        cpu_hold,
    output logic [15:0] word_count
);

    import imem_pkg::*;

    localparam logic [16:0] WORDS_MAX = 17'(MEM_BYTES / 4);

    state_e      state_q, state_d;
    logic [15:0] n_q, n_d;
    logic [15:0] word_count_q, word_count_d;
    logic        in_ready_q, in_ready_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic        cpu_hold_q, cpu_hold_d;

    logic        accept;
    logic        pk_clear;
    logic        pk_en;
    logic        pk_ready;
    logic [31:0] pk_word;

    assign accept   = in_valid && in_ready_q;
    assign pk_en    = accept && (state_q == DATA);
    assign pk_clear = start && (state_q inside {IDLE, DONE, ERROR});

    imem_word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (pk_clear),
        .byte_en    (pk_en),
        .byte_in    (in_data),
        .word_next  (pk_word),
        .word_ready (pk_ready)
    );

    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        word_count_d = word_count_q;
        case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_d      = LEN_HI;
                    word_count_d = '0;
                end
            end
            LEN_HI: begin
                if (accept) begin
                    n_d     = {in_data, n_q[7:0]};
                    state_d = LEN_LO;
                end
            end
            LEN_LO: begin
                if (accept) begin
                    n_d = {n_q[15:8], in_data};
                    if (n_d == 16'd0)                  state_d = DONE;
                    else if ({1'b0, n_d} > WORDS_MAX)  state_d = ERROR;
                    else                               state_d = DATA;
                end
            end
            DATA: begin
                if (pk_ready) state_d = WRITE;
            end
            WRITE: begin
                word_count_d = word_count_q + 16'd1;
                state_d      = (word_count_d == n_q) ? DONE : DATA;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        in_ready_d  = state_d inside {LEN_HI, LEN_LO, DATA};
        mem_we_d    = (state_d == WRITE);
        mem_addr_d  = mem_we_d ? {14'd0, word_count_d, 2'b00} : 32'd0;
        mem_wdata_d = mem_we_d ? pk_word : 32'd0;
        busy_d      = state_d inside {LEN_HI, LEN_LO, DATA, WRITE};
        done_d      = (state_d == DONE);
        error_d     = (state_d == ERROR);
        cpu_hold_d  = (state_d != DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            n_q          <= '0;
            word_count_q <= '0;
            in_ready_q   <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            cpu_hold_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            word_count_q <= word_count_d;
            in_ready_q   <= in_ready_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            cpu_hold_q   <= cpu_hold_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign cpu_hold   = cpu_hold_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: the expected write list of every load
// is derived from the stream contents, then compared with the observed writes.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic        cpu_hold;
    logic [15:0] word_count;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];
    logic        prev_we = 1'b0;
    bit          rand_valid = 1'b0;
    bit          inject_start = 1'b0;

    imem_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .cpu_hold   (cpu_hold),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    // Bus monitor: records writes and checks the per-cycle write-port rules.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            got_addr.push_back(mem_addr);
            got_data.push_back(mem_wdata);
            n_cmp++;
            if (in_ready !== 1'b0 || busy !== 1'b1) begin
                n_bad++;
                $display("FAIL write_phase: in_ready=%b busy=%b, required in_ready=0 busy=1", in_ready, busy);
            end
            n_cmp++;
            if (prev_we !== 1'b0) begin
                n_bad++;
                $display("FAIL write_pulse: mem_we high two cycles in a row, required single-cycle pulse");
            end
        end else begin
            n_cmp++;
            if (mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
                n_bad++;
                $display("FAIL idle_bus: addr=%h data=%h, required 0/0 while mem_we=0", mem_addr, mem_wdata);
            end
        end
        prev_we = mem_we;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        bit   acc = 1'b0;
        bit   v;
        logic r;
        int   guard = 0;
        while (!acc) begin
            @(negedge clk);
            v        = rand_valid ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_valid = v;
            in_data  = b;
            start    = inject_start;
            inject_start = 1'b0;
            r = in_ready;
            @(posedge clk);
            acc = v && (r === 1'b1);
            guard++;
            if (!acc && guard > 100) begin
                n_cmp++;
                n_bad++;
                $display("FAIL byte_accept: byte %h not accepted within 100 cycles, required acceptance", b);
                return;
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_end(output int cycles);
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
        cycles   = 1;
        while (!(done === 1'b1 || error === 1'b1) && cycles < 200) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    // Full load: builds the stream, drives it, and compares against the
    // expected outcome (writes to 4*i of word i, or rejection when too long).
    task automatic run_load(input int n, input logic [31:0] fw[$], input bit rv, input int inj_at, input string tag);
        logic [31:0] words[$];
        logic [15:0] nn;
        bit          bad;
        int          cyc;
        int          exp_writes;
        nn  = n[15:0];
        bad = (n > 1024);
        words.delete();
        if (!bad) begin
            for (int i = 0; i < n; i++)
                words.push_back((fw.size() == n) ? fw[i] : $urandom());
        end
        exp_writes = bad ? 0 : n;

        pulse_start();
        got_addr.delete();
        got_data.delete();
        rand_valid = rv;
        send_byte(nn[15:8]);
        send_byte(nn[7:0]);
        for (int i = 0; i < words.size(); i++) begin
            for (int b = 0; b < 4; b++) begin
                if (i * 4 + b == inj_at) inject_start = 1'b1;
                send_byte(words[i][31 - 8 * b -: 8]);
            end
        end
        rand_valid = 1'b0;
        wait_end(cyc);

        n_cmp++;
        if (cyc >= 200) begin
            n_bad++;
            $display("FAIL %s end_timeout: done=%b error=%b after %0d cycles, required done or error", tag, done, error, cyc);
        end
        if (n == 0) begin
            n_cmp++;
            if (cyc > 2) begin
                n_bad++;
                $display("FAIL %s zero_len_latency: done after %0d cycles, required <= 2", tag, cyc);
            end
        end
        n_cmp++;
        if (done !== !bad || error !== bad) begin
            n_bad++;
            $display("FAIL %s status: done=%b error=%b, required done=%b error=%b", tag, done, error, !bad, bad);
        end
        n_cmp++;
        if (cpu_hold !== bad || busy !== 1'b0 || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL %s end_flags: cpu_hold=%b busy=%b in_ready=%b, required %b/0/0", tag, cpu_hold, busy, in_ready, bad);
        end
        n_cmp++;
        if (word_count !== 16'(exp_writes)) begin
            n_bad++;
            $display("FAIL %s word_count: got %0d, required %0d", tag, word_count, exp_writes);
        end
        n_cmp++;
        if (got_addr.size() != exp_writes) begin
            n_bad++;
            $display("FAIL %s write_count: got %0d writes, required %0d", tag, got_addr.size(), exp_writes);
        end else begin
            for (int i = 0; i < exp_writes; i++) begin
                n_cmp++;
                if (got_addr[i] !== 32'(4 * i) || got_data[i] !== words[i]) begin
                    n_bad++;
                    $display("FAIL %s write[%0d]: addr=%h data=%h, required addr=%h data=%h",
                             tag, i, got_addr[i], got_data[i], 32'(4 * i), words[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({in_ready, mem_we, busy, done, error, cpu_hold} !== 6'b000001) begin
            n_bad++;
            $display("FAIL reset_flags: rdy/we/busy/done/err/hold=%b%b%b%b%b%b, required 000001",
                     in_ready, mem_we, busy, done, error, cpu_hold);
        end
        n_cmp++;
        if (word_count !== 16'd0 || mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_values: wc=%0d addr=%h data=%h, required 0", word_count, mem_addr, mem_wdata);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || cpu_hold !== 1'b1) begin
            n_bad++;
            $display("FAIL idle_after_reset: in_ready=%b busy=%b cpu_hold=%b, required 0/0/1", in_ready, busy, cpu_hold);
        end
    endtask

    task automatic test_single_word();
        logic [31:0] w[$];
        w = '{32'h0090_0493};
        run_load(1, w, 1'b0, -1, "single");
    endtask

    task automatic test_three_words();
        logic [31:0] w[$];
        w = '{32'h0090_0493, 32'h0050_0293, 32'hFE54_AE23};
        run_load(3, w, 1'b0, -1, "three");
    endtask

    task automatic test_length_limits();
        logic [31:0] w[$];
        w.delete();
        run_load(1025, w, 1'b0, -1, "too_long");
        run_load(0, w, 1'b0, -1, "zero_len");
        run_load(1024, w, 1'b0, -1, "max_len");
    endtask

    task automatic test_random_valid();
        logic [31:0] w[$];
        int n;
        w.delete();
        for (int k = 0; k < 4; k++) begin
            n = $urandom_range(3, 8);
            run_load(n, w, 1'b1, $urandom_range(1, 4 * n - 2), "rand_valid");
        end
    endtask

    task automatic test_reset_mid_load();
        logic [31:0] w[$];
        logic [31:0] w0;
        w0 = 32'hA5C3_0F1E;
        pulse_start();
        got_addr.delete();
        got_data.delete();
        send_byte(8'h00);
        send_byte(8'h02);
        for (int b = 0; b < 4; b++) send_byte(w0[31 - 8 * b -: 8]);
        send_byte(8'h11);
        send_byte(8'h22);
        @(negedge clk);
        in_valid = 1'b0;
        #1 reset = 1'b1;
        #1;
        n_cmp++;
        if ({in_ready, mem_we, busy, done, error, cpu_hold} !== 6'b000001 || word_count !== 16'd0) begin
            n_bad++;
            $display("FAIL mid_reset_flags: rdy/we/busy/done/err/hold=%b%b%b%b%b%b wc=%0d, required 000001 wc=0",
                     in_ready, mem_we, busy, done, error, cpu_hold, word_count);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (got_addr.size() != 1) begin
            n_bad++;
            $display("FAIL mid_reset_writes: got %0d writes, required 1", got_addr.size());
        end else begin
            n_cmp++;
            if (got_addr[0] !== 32'd0 || got_data[0] !== w0) begin
                n_bad++;
                $display("FAIL mid_reset_word0: addr=%h data=%h, required 0/%h", got_addr[0], got_data[0], w0);
            end
        end
        w = '{32'h1357_9BDF, 32'h2468_ACE0};
        run_load(2, w, 1'b0, -1, "after_reset");
    endtask

    task automatic test_back_to_back();
        logic [31:0] w[$];
        w.delete();
        for (int k = 0; k < 3; k++)
            run_load($urandom_range(1, 5), w, 1'b0, -1, "b2b");
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        test_reset();
        test_single_word();
        test_three_words();
        test_length_limits();
        test_random_valid();
        test_reset_mid_load();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
